// File: rtl/alu_stream.sv
// alu_stream: handshaked ALU with single-cycle logic/arith ops and an
// iterative shift-add unsigned multiplier feeding a holding output register.
module alu_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_zero,
    output logic                 out_carry
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_d;
    logic [RW-1:0]     result_d;
    logic              zero_d;
    logic              carry_d;

    logic [RW-1:0]     alu_res;
    logic              alu_carry;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  shl_v;
    logic [WIDTH-1:0]  shr_v;
    logic [SW-1:0]     shamt;
    logic [RW-1:0]     addend;
    logic [RW-1:0]     acc_sum;
    logic              accept;

    // Single-cycle operation results for the currently offered transaction
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        shamt     = in_b[SW-1:0];
        sum       = {1'b0, in_a} + {1'b0, in_b};
        diff      = in_a - in_b;
        shl_v     = in_a << shamt;
        shr_v     = in_a >> shamt;
        case (in_op)
            OP_ADD: begin
                alu_res   = RW'(sum);
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = RW'(diff);
                alu_carry = (in_a < in_b);
            end
            OP_OR:   alu_res = RW'(in_a | in_b);
            OP_AND:  alu_res = RW'(in_a & in_b);
            OP_XOR:  alu_res = RW'(in_a ^ in_b);
            OP_SHL:  alu_res = RW'(shl_v);
            OP_SHR:  alu_res = RW'(shr_v);
            default: alu_res = '0;
        endcase
    end

    // Next-state, multiplier datapath, output register and in_ready
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = out_valid;
        result_d = out_result;
        zero_d   = out_zero;
        carry_d  = out_carry;
        in_ready = 1'b0;
        accept   = 1'b0;
        addend   = mplier_q[0] ? mcand_q : '0;
        acc_sum  = acc_q + addend;

        // A transfer frees the output register unless a load below refills it
        if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                in_ready = !rst && (!out_valid || out_ready);
                accept   = in_valid && in_ready;
                if (accept) begin
                    if (in_op == OP_MUL) begin
                        mcand_d  = RW'(in_a);
                        mplier_d = in_b;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_carry;
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                    carry_d  = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_valid  <= valid_d;
            out_result <= result_d;
            out_zero   <= zero_d;
            out_carry  <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream (WIDTH=8): vector table, scoreboard and corner sequences.
module tb_alu_stream;

    typedef struct packed {
        logic [15:0] res;
        logic        zero;
        logic        carry;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        zero;
        logic        carry;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_carry;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t sbq[$];
    int out_cycles[$];
    exp_t mon_e;

    alu_stream #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned r;
        logic c;
        exp_t e;
        ua = 32'(a);
        ub = 32'(b);
        r = 0;
        c = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 255); end
            3'd1: begin r = (ua - ub) & 255; c = (ua < ub); end
            3'd2: r = ua * ub;
            3'd3: r = ua | ub;
            3'd4: r = ua & ub;
            3'd5: r = ua ^ ub;
            3'd6: r = (ua << (ub % 8)) & 255;
            default: r = ua >> (ub % 8);
        endcase
        e.res = 16'(r);
        e.zero = (r == 0);
        e.carry = c;
        return e;
    endfunction

    // Scoreboard: pop and compare on every output transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%0h required=none", out_result);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_result", 32'(out_result), 32'(mon_e.res));
                chk("out_zero", 32'(out_zero), 32'(mon_e.zero));
                chk("out_carry", 32'(out_carry), 32'(mon_e.carry));
            end
            out_cycles.push_back(cyc);
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, output int waits);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        sbq.push_back(e);
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 100);
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=%0d required=<100", waits);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    vec_t vecs[12];
    exp_t e;
    int w;
    int k;
    int rdy_bad;
    logic [2:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b1};
        vecs[1]  = '{3'd1, 8'd5,   8'd7,   16'h00FE, 1'b0, 1'b1};
        vecs[2]  = '{3'd4, 8'hF0,  8'h0F,  16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{3'd6, 8'h81,  8'd9,   16'h0002, 1'b0, 1'b0};
        vecs[4]  = '{3'd7, 8'h80,  8'd7,   16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{3'd3, 8'h0A,  8'h50,  16'h005A, 1'b0, 1'b0};
        vecs[6]  = '{3'd5, 8'hFF,  8'hFF,  16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{3'd0, 8'd255, 8'd1,   16'h0100, 1'b0, 1'b1};
        vecs[8]  = '{3'd1, 8'd7,   8'd7,   16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{3'd2, 8'd0,   8'd9,   16'h0000, 1'b1, 1'b0};
        vecs[10] = '{3'd2, 8'd15,  8'd17,  16'h00FF, 1'b0, 1'b0};
        vecs[11] = '{3'd6, 8'h01,  8'd7,   16'h0080, 1'b0, 1'b0};

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_zero", 32'(out_zero), 0);
        chk("rst_out_carry", 32'(out_carry), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            e.res = vecs[i].res;
            e.zero = vecs[i].zero;
            e.carry = vecs[i].carry;
            send(vecs[i].op, vecs[i].a, vecs[i].b, e, w);
            if (vecs[i].op != 3'd2) begin
                chk("nonmul_latency_valid", 32'(out_valid), 1);
                chk("nonmul_in_ready", 32'(in_ready), 1);
            end
        end

        // MUL 255*255: latency and in_ready low
        @(posedge clk);
        #1;
        e.res = 16'hFE01; e.zero = 1'b0; e.carry = 1'b0;
        send(3'd2, 8'd255, 8'd255, e, w);
        k = 0;
        rdy_bad = 0;
        while (!out_valid && k < 30) begin
            if (in_ready) rdy_bad++;
            @(posedge clk);
            #1;
            k++;
        end
        chk("mul_latency", 32'(k), 8);
        chk("mul_in_ready_low", 32'(rdy_bad), 0);

        // Backpressure: ADD 1+1 held, XOR 3^5 stalled until release
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        e.res = 16'd2; e.zero = 1'b0; e.carry = 1'b0;
        send(3'd0, 8'd1, 8'd1, e, w);
        in_valid = 1'b1; in_op = 3'd5; in_a = 8'd3; in_b = 8'd5;
        sbq.push_back(model(3'd5, 8'd3, 8'd5));
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_hold_result", 32'(out_result), 2);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_result", 32'(out_result), 6);
        chk("bp_next_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        chk("bp_drained", 32'(out_valid), 0);

        // Back-to-back random non-MUL stream
        out_cycles.delete();
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 6));
            if (rop == 3'd2) rop = 3'd7;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(rop, ra, rb, model(rop, ra, rb), w);
        end
        k = 0;
        while (out_cycles.size() < 16 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("stream_count", 32'(out_cycles.size()), 16);
        if (out_cycles.size() >= 16)
            chk("stream_span", 32'(out_cycles[15] - out_cycles[0]), 15);

        // Reset in the middle of MUL 12*13
        e.res = 16'd10; e.zero = 1'b0; e.carry = 1'b0;
        send(3'd0, 8'd5, 8'd5, e, w);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_op = 3'd2; in_a = 8'd12; in_b = 8'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_result", 32'(out_result), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rerun_in_ready", 32'(in_ready), 1);
        e.res = 16'd3; e.zero = 1'b0; e.carry = 1'b0;
        send(3'd0, 8'd1, 8'd2, e, w);
        chk("rerun_accept_first", 32'(w), 1);

        // Drain and confirm nothing was lost
        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (12) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
